muldiv_unit: RTL and testbench

- Iterative multiply/divide unit that owns the architectural HI/LO registers for the single-cycle core.
- Sits downstream of the control unit and register file: consumes rs/rt operands plus a decoded mult/div opcode, and produces the HI/LO values the ALU reads for MFHI/MFLO.
- Provides a start/busy/done handshake so the core can stall while an operation runs.
- Also services MTHI/MTLO writes.

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO registers
//
// Purpose:
//   Runs MULTU/MULT/DIVU/DIV over WIDTH iterations (radix-2 shift-add and
//   restoring shift-subtract on operand magnitudes). A final FIX cycle applies
//   sign correction and writes HI/LO in one step, so HI/LO never show partial
//   results. MTHI/MTLO writes are also accepted while idle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request a new operation (sampled only while idle)
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b         rs / rt operands
//   hi_we, lo_we MTHI / MTLO write strobes (idle only, start has priority)
//   wdata        MTHI / MTLO data
//   busy         operation in progress
//   done         one-cycle pulse when HI/LO were just written by mult/div
//   div_by_zero  last division had b==0; cleared by the next accepted start
//   hi, lo       architectural HI / LO registers

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_m;         // mul: |multiplicand|; div: |divisor|
  logic               r_is_div;
  logic               r_sa;
  logic               r_sb;
  logic               r_dbz_pend;
  logic               r_busy;
  logic               r_done;
  logic               r_div_by_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_last;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic               w_neg_res;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // op[0] marks the signed variants; unsigned ops never see a sign flag.
  assign w_a_neg = op[0] & a[WIDTH-1];
  assign w_b_neg = op[0] & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, keeping the carry, then shift right by one.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
  assign w_mul_nxt = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring divide: remainder shifted left with the next dividend bit.
  // The remainder stays below the divisor, so the borrow bit of the
  // difference alone tells whether the subtraction fits.
  assign w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = w_div_sh - {1'b0, r_m};
  assign w_div_nxt  = w_div_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction. With b==0 the restoring loop leaves |a| as the
  // remainder, so negating by sign(a) recovers the raw a for HI.
  assign w_neg_res = r_sa ^ r_sb;
  assign w_prod    = w_neg_res ? -r_acc : r_acc;
  assign w_quo     = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem     = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_acc         <= '0;
      r_m           <= '0;
      r_is_div      <= 1'b0;
      r_sa          <= 1'b0;
      r_sb          <= 1'b0;
      r_dbz_pend    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div      <= op[1];
            r_sa          <= w_a_neg;
            r_sb          <= w_b_neg;
            r_dbz_pend    <= op[1] && (b == '0);
            r_m           <= op[1] ? w_b_mag : w_a_mag;
            r_acc         <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            r_cnt         <= '0;
            r_busy        <= 1'b1;
            r_div_by_zero <= 1'b0;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= r_dbz_pend ? {WIDTH{1'b1}} : w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          if (r_dbz_pend) r_div_by_zero <= 1'b1;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit

module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   failures;
  int   done_seen;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  // Called at a negedge; drives start for one accept edge and returns at the
  // negedge right after that edge.
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic push, input logic [31:0] eh,
                       input logic [31:0] el, input logic ed);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    if (push) begin
      e.name = name; e.hi = eh; e.lo = el; e.dbz = ed;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
  endtask

  initial begin
    int n;
    int dones_before;
    checks = 0; failures = 0; done_seen = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk);

    // MULTU max*max with latency measurement
    issue("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("multu_busy_cycles", n, 32'd33);
    check("multu_done_after_busy", {31'd0, done}, 32'd1);
    @(negedge clk);

    // MULT signed, then back-to-back MULT started in the done cycle
    issue("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    wait_done("mult_neg");
    issue("mult_b2b", 2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h3FFFFFFF, 32'h00000001, 1'b0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("mult_b2b");
    @(negedge clk);

    // Divides
    issue("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done("div_neg");
    @(negedge clk);
    issue("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    wait_done("divu_100_7");
    @(negedge clk);
    issue("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b0);
    wait_done("div_ovf");
    @(negedge clk);

    // Divide by zero
    issue("divu_zero", 2'b10, 32'h1234, 32'd0, 1'b1, 32'h1234, 32'hFFFFFFFF, 1'b1);
    wait_done("divu_zero");
    repeat (3) @(negedge clk);
    check("dbz_held", {31'd0, div_by_zero}, 32'd1);
    issue("multu_2_3", 2'b00, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0);
    check("dbz_cleared_on_start", {31'd0, div_by_zero}, 32'd0);
    wait_done("multu_2_3");
    @(negedge clk);
    issue("div_neg_zero", 2'b11, 32'hFFFFFFF8, 32'd0, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1);
    wait_done("div_neg_zero");
    @(negedge clk);

    // MTHI/MTLO
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h77;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", hi, 32'h77);
    check("mt_both_lo", lo, 32'h77);
    hi_we = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi", hi, 32'hAAAA);
    check("mtlo", lo, 32'h5555);

    // start and hi_we during a run are dropped; HI/LO hold until FIX
    issue("multu_2_2", 2'b00, 32'd2, 32'd2, 1'b1, 32'd0, 32'd4, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("midrun_hi_hold", hi, 32'hAAAA);
    check("midrun_lo_hold", lo, 32'h5555);
    check("midrun_busy", {31'd0, busy}, 32'd1);
    wait_done("multu_2_2");
    repeat (5) @(negedge clk);
    check("no_queued_op", {31'd0, busy}, 32'd0);

    // start wins over hi_we on the same idle edge
    hi_we = 1'b1; wdata = 32'hBEEF;
    issue("multu_3_3", 2'b00, 32'd3, 32'd3, 1'b1, 32'd0, 32'd9, 1'b0);
    hi_we = 1'b0;
    check("start_beats_mthi", hi, 32'd0);
    wait_done("multu_3_3");
    @(negedge clk);

    // rst mid-operation
    issue("div_abort", 2'b11, 32'd50, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    dones_before = done_seen;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_seen - dones_before, 32'd0);
    issue("divu_50_5", 2'b10, 32'd50, 32'd5, 1'b1, 32'd0, 32'd10, 1'b0);
    wait_done("divu_50_5");
    @(negedge clk);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
